// File: rtl/excess3_serializer.sv
// excess3_serializer: decodes excess-3 digits to BCD and shifts them out LSB first in back-to-back frames
module excess3_serializer #(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  x,
  output logic                  bit_valid,
  output logic                  frame_start,
  output logic                  frame_last,
  output logic                  code_err
);
  localparam int N = 4*DIGITS;
  localparam int CW = (N > 4) ? $clog2(N) : 2;
  localparam logic [CW-1:0] LAST = CW'(N-1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] sr, dec;
  logic [DIGITS-1:0] bad;
  logic last, accept;
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      logic [3:0] nib;
      assign nib = in_data[4*k +: 4];
      assign bad[k] = nib < 4'd3 || nib > 4'd12;
      assign dec[4*k +: 4] = bad[k] ? 4'd0 : nib - 4'd3;
    end
  endgenerate
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      code_err <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        sr       <= dec;
        cnt      <= '0;
        code_err <= |bad;
      end else if (state == SHIFT) begin
        sr  <= sr >> 1;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  always_comb nxt = (accept || (state == SHIFT && !last)) ? SHIFT : IDLE;
  // the last-bit cycle doubles as the accept window so frames abut without a gap
  always_comb begin
    last        = state == SHIFT && cnt == LAST;
    in_ready    = state == IDLE || last;
    bit_valid   = state == SHIFT;
    x           = state == SHIFT && sr[0];
    frame_start = state == SHIFT && cnt == '0;
    frame_last  = last;
  end
endmodule

// File: tb/tb_excess3_serializer.sv
// tb_excess3_serializer: directed checks of the excess-3 serializer at DIGITS=1 and DIGITS=2
module tb_excess3_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic v1 = 1'b0, r1, x1, bv1, fs1, fl1, ce1;
  logic [3:0] d1 = '0;
  logic v2 = 1'b0, r2, x2, bv2, fs2, fl2, ce2;
  logic [7:0] d2 = '0;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] e;

  always #5 clk = ~clk;

  excess3_serializer #(.DIGITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .x(x1), .bit_valid(bv1), .frame_start(fs1), .frame_last(fl1), .code_err(ce1)
  );

  excess3_serializer #(.DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .x(x2), .bit_valid(bv2), .frame_start(fs2), .frame_last(fl2), .code_err(ce2)
  );

  task test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({r1, bv1, fs1, fl1, x1, ce1} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_u1 {rdy,bv,fs,fl,x,err} got %b want 100000", {r1, bv1, fs1, fl1, x1, ce1});
    end
    n_cmp++;
    if ({r2, bv2, fs2, fl2, x2, ce2} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_u2 {rdy,bv,fs,fl,x,err} got %b want 100000", {r2, bv2, fs2, fl2, x2, ce2});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task test_single;
    logic [3:0] dd;
    dd = 4'd4;
    @(negedge clk);
    v1 = 1'b1;
    d1 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = {1'b1, i == 0, i == 3, dd[i], i == 3, 1'b0};
      n_cmp++;
      if ({bv1, fs1, fl1, x1, r1, ce1} !== e) begin
        n_bad++;
        $display("FAIL single_bit%0d {bv,fs,fl,x,rdy,err} got %b want %b", i, {bv1, fs1, fl1, x1, r1, ce1}, e);
      end
      v1 = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({bv1, x1, r1, ce1} !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_idle {bv,x,rdy,err} got %b want 0010", {bv1, x1, r1, ce1});
    end
  endtask

  task test_stream;
    logic [3:0] dg;
    int acc;
    acc = 0;
    @(negedge clk);
    v1 = 1'b1;
    d1 = 4'd3;
    if (v1 && r1) acc++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dg = 4'(i / 4);
      e = {1'b1, i % 4 == 0, i % 4 == 3, dg[i % 4], i % 4 == 3, 1'b0};
      n_cmp++;
      if ({bv1, fs1, fl1, x1, r1, ce1} !== e) begin
        n_bad++;
        $display("FAIL stream_bit%0d {bv,fs,fl,x,rdy,err} got %b want %b", i, {bv1, fs1, fl1, x1, r1, ce1}, e);
      end
      if (i % 4 == 3) begin
        if (i == 39) v1 = 1'b0;
        else d1 = 4'(3 + i / 4 + 1);
      end
      if (v1 && r1) acc++;
    end
    n_cmp++;
    if (acc !== 10) begin
      n_bad++;
      $display("FAIL stream_accepts got %0d want 10", acc);
    end
    @(negedge clk);
    n_cmp++;
    if ({bv1, r1} !== 2'b01) begin
      n_bad++;
      $display("FAIL stream_idle {bv,rdy} got %b want 01", {bv1, r1});
    end
  endtask

  task test_illegal;
    logic [3:0] cd [3];
    logic [3:0] ed [3];
    logic [2:0] ee;
    logic [3:0] t;
    cd = '{4'b0001, 4'b1101, 4'b1000};
    ed = '{4'd0, 4'd0, 4'd5};
    ee = 3'b011;
    @(negedge clk);
    v1 = 1'b1;
    d1 = cd[0];
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        t = ed[f];
        e = {1'b1, b == 0, b == 3, t[b], b == 3, ee[f]};
        n_cmp++;
        if ({bv1, fs1, fl1, x1, r1, ce1} !== e) begin
          n_bad++;
          $display("FAIL illegal_f%0d_bit%0d {bv,fs,fl,x,rdy,err} got %b want %b", f, b, {bv1, fs1, fl1, x1, r1, ce1}, e);
        end
        if (b == 3) begin
          if (f == 2) v1 = 1'b0;
          else d1 = cd[f+1];
        end
      end
    @(negedge clk);
    n_cmp++;
    if ({bv1, ce1} !== 2'b00) begin
      n_bad++;
      $display("FAIL illegal_idle {bv,err} got %b want 00", {bv1, ce1});
    end
  endtask

  task test_two_digit;
    logic [7:0] dd;
    dd = 8'h51;
    @(negedge clk);
    v2 = 1'b1;
    d2 = 8'b1000_0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = {1'b1, i == 0, i == 7, dd[i], i == 7, 1'b0};
      n_cmp++;
      if ({bv2, fs2, fl2, x2, r2, ce2} !== e) begin
        n_bad++;
        $display("FAIL two_digit_bit%0d {bv,fs,fl,x,rdy,err} got %b want %b", i, {bv2, fs2, fl2, x2, r2, ce2}, e);
      end
      v2 = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({bv2, r2} !== 2'b01) begin
      n_bad++;
      $display("FAIL two_digit_idle {bv,rdy} got %b want 01", {bv2, r2});
    end
  endtask

  task test_reset_mid;
    @(negedge clk);
    v1 = 1'b1;
    d1 = 4'b1000;
    v2 = 1'b1;
    d2 = 8'b1000_0000;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({x1, bv1, r1, bv2, ce2} !== 5'b11011) begin
      n_bad++;
      $display("FAIL mid_pre {x1,bv1,rdy1,bv2,err2} got %b want 11011", {x1, bv1, r1, bv2, ce2});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({x1, bv1, fs1, fl1, r1, ce1} !== 6'b000010) begin
      n_bad++;
      $display("FAIL mid_async_u1 {x,bv,fs,fl,rdy,err} got %b want 000010", {x1, bv1, fs1, fl1, r1, ce1});
    end
    n_cmp++;
    if ({x2, bv2, r2, ce2} !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_async_u2 {x,bv,rdy,err} got %b want 0010", {x2, bv2, r2, ce2});
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bv1, r1, bv2} !== 3'b010) begin
      n_bad++;
      $display("FAIL mid_idle {bv1,rdy1,bv2} got %b want 010", {bv1, r1, bv2});
    end
    v1 = 1'b1;
    d1 = 4'b0100;
    @(negedge clk);
    v1 = 1'b0;
    n_cmp++;
    if ({bv1, fs1, fl1, x1} !== 4'b1101) begin
      n_bad++;
      $display("FAIL mid_fresh0 {bv,fs,fl,x} got %b want 1101", {bv1, fs1, fl1, x1});
    end
    @(negedge clk);
    n_cmp++;
    if ({bv1, fs1, fl1, x1} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_fresh1 {bv,fs,fl,x} got %b want 1000", {bv1, fs1, fl1, x1});
    end
    repeat (3) @(negedge clk);
  endtask

  task test_ignore;
    logic [3:0] junk [3];
    logic [3:0] dd;
    junk = '{4'b0011, 4'b1100, 4'b0001};
    @(negedge clk);
    v1 = 1'b1;
    d1 = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dd = (i < 4) ? 4'd5 : 4'd3;
      e = {1'b1, i % 4 == 0, i % 4 == 3, dd[i % 4], i % 4 == 3, 1'b0};
      n_cmp++;
      if ({bv1, fs1, fl1, x1, r1, ce1} !== e) begin
        n_bad++;
        $display("FAIL ignore_bit%0d {bv,fs,fl,x,rdy,err} got %b want %b", i, {bv1, fs1, fl1, x1, r1, ce1}, e);
      end
      if (i == 3) d1 = 4'b0110;
      else if (i == 7) v1 = 1'b0;
      else d1 = junk[i % 4];
    end
    @(negedge clk);
    n_cmp++;
    if ({bv1, r1, ce1} !== 3'b010) begin
      n_bad++;
      $display("FAIL ignore_idle {bv,rdy,err} got %b want 010", {bv1, r1, ce1});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_illegal;
    test_two_digit;
    test_reset_mid;
    test_ignore;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
